// File: rtl/bus_arbiter_2m.sv
// rtl/bus_arbiter_2m.sv - two-master round-robin arbiter onto a single-outstanding memory bus
module bus_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic [31:0] i_m0_data,
    input  logic [31:0] i_m0_address,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write_notread,
    input  logic        i_m0_DV,
    output logic [31:0] o_m0_data,
    output logic        o_m0_DV,

    input  logic [31:0] i_m1_data,
    input  logic [31:0] i_m1_address,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write_notread,
    input  logic        i_m1_DV,
    output logic [31:0] o_m1_data,
    output logic        o_m1_DV,

    output logic [31:0] o_mem_data,
    output logic [31:0] o_mem_address,
    output logic [2:0]  o_mem_bhw,
    output logic        o_mem_write_notread,
    output logic        o_mem_DV,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_DV,

    output logic        o_timeout,
    output logic        o_protocol_err
);

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] address;
        logic [2:0]  bhw;
        logic        write_notread;
    } req_t;

    state_t        state_q;
    logic          owner_q;
    logic          last_grant_q;
    logic [CW-1:0] cnt_q;

    logic          pend0_q, pend0_d;
    logic          pend1_q, pend1_d;
    req_t          req0_q, req0_d;
    req_t          req1_q, req1_d;

    logic          leave_wait;
    logic          busy0, busy1;
    logic          accept0, accept1;
    logic          drop0, drop1;
    logic          grant0, grant1;
    logic          spurious;
    req_t          win_req;
    logic [31:0]   rsp_data;

    // A master stops being "in flight" on the very edge its transaction ends,
    // so a request arriving on that edge is latched rather than dropped.
    always_comb begin
        leave_wait = (state_q == ST_WAIT) && (i_mem_DV || (cnt_q == CNT_LAST));
        busy0      = (state_q == ST_WAIT) && !owner_q && !leave_wait;
        busy1      = (state_q == ST_WAIT) &&  owner_q && !leave_wait;
        accept0    = i_m0_DV && !pend0_q && !busy0;
        accept1    = i_m1_DV && !pend1_q && !busy1;
        drop0      = i_m0_DV && !accept0;
        drop1      = i_m1_DV && !accept1;
        spurious   = (state_q == ST_IDLE) && i_mem_DV;
        grant1     = (state_q == ST_IDLE) && pend1_q && (!pend0_q || !last_grant_q);
        grant0     = (state_q == ST_IDLE) && pend0_q && !grant1;
        win_req    = grant1 ? req1_q : req0_q;
        rsp_data   = i_mem_DV ? i_mem_data : TIMEOUT_DATA;
    end

    always_comb begin
        pend0_d = pend0_q;
        req0_d  = req0_q;
        if (grant0) begin
            pend0_d = 1'b0;
        end
        if (accept0) begin
            pend0_d = 1'b1;
            req0_d  = '{data: i_m0_data, address: i_m0_address,
                        bhw: i_m0_bhw, write_notread: i_m0_write_notread};
        end
    end

    always_comb begin
        pend1_d = pend1_q;
        req1_d  = req1_q;
        if (grant1) begin
            pend1_d = 1'b0;
        end
        if (accept1) begin
            pend1_d = 1'b1;
            req1_d  = '{data: i_m1_data, address: i_m1_address,
                        bhw: i_m1_bhw, write_notread: i_m1_write_notread};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            req0_q  <= '0;
            req1_q  <= '0;
        end else begin
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            req0_q  <= req0_d;
            req1_q  <= req1_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q             <= ST_IDLE;
            owner_q             <= 1'b0;
            last_grant_q        <= 1'b1;
            cnt_q               <= '0;
            o_mem_data          <= '0;
            o_mem_address       <= '0;
            o_mem_bhw           <= '0;
            o_mem_write_notread <= 1'b0;
            o_mem_DV            <= 1'b0;
            o_m0_data           <= '0;
            o_m0_DV             <= 1'b0;
            o_m1_data           <= '0;
            o_m1_DV             <= 1'b0;
            o_timeout           <= 1'b0;
            o_protocol_err      <= 1'b0;
        end else begin
            o_mem_DV <= 1'b0;
            o_m0_DV  <= 1'b0;
            o_m1_DV  <= 1'b0;
            if (drop0 || drop1 || spurious) begin
                o_protocol_err <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        o_mem_data          <= win_req.data;
                        o_mem_address       <= win_req.address;
                        o_mem_bhw           <= win_req.bhw;
                        o_mem_write_notread <= win_req.write_notread;
                        o_mem_DV            <= 1'b1;
                        owner_q             <= grant1;
                        last_grant_q        <= grant1;
                        cnt_q               <= '0;
                        state_q             <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response on the expiry edge takes priority over the timeout.
                    if (leave_wait) begin
                        state_q <= ST_IDLE;
                        if (owner_q) begin
                            o_m1_data <= rsp_data;
                            o_m1_DV   <= 1'b1;
                        end else begin
                            o_m0_data <= rsp_data;
                            o_m0_DV   <= 1'b1;
                        end
                        if (!i_mem_DV) begin
                            o_timeout <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
